// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter
package dmem_arb_pkg;
    typedef enum logic [0:0] {ARB, LOCKED} arb_state_e;
    localparam int P_CPU     = 0;
    localparam int P_DMA     = 1;
    localparam int MEM_WORDS = 1024;
    localparam int MEM_BYTES = MEM_WORDS * 4;
endpackage

// File: rtl/dmem_arb_addr_check.sv
// dmem_arb_addr_check: flags addresses outside the data memory or not word aligned
//   addr in  ADDR_W  byte address of the selected request
//   err  out 1       1 = access must be rejected
module dmem_arb_addr_check import dmem_arb_pkg::*; #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              err
);
    always_comb err = |(addr >> $clog2(MEM_BYTES)) || |addr[1:0];
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter with bounded lock bursts in front of the data memory
//   clk, rst                          clock, async active-high reset
//   req/we/addr/wdata/lock 0,1        requester inputs (0 = CPU, 1 = DMA/debug)
//   gnt 0,1                           combinational grant
//   rsp_valid/rsp_err/rdata 0,1       registered response one cycle after grant
//   mem_addr/mem_write_data/mem_read/mem_write/mem_read_data  memory side
module dmem_arbiter import dmem_arb_pkg::*; #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              lock0,
    output logic              gnt0,
    output logic              rsp_valid0,
    output logic              rsp_err0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock1,
    output logic              gnt1,
    output logic              rsp_valid1,
    output logic              rsp_err1,
    output logic [DATA_W-1:0] rdata1,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_read_data
);
    arb_state_e        state;
    logic              owner, prio, rd0, rd1;
    logic [3:0]        cnt;
    logic              hold, any, sel, sel_we, sel_lock, err;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // hold: the lock owner is still requesting, so it keeps the grant this cycle;
    // otherwise plain round-robin (when the owner drops req only the other port can be requesting)
    always_comb begin
        hold      = state == LOCKED && (owner ? req1 : req0);
        sel       = hold ? owner : (req0 && req1 ? prio : req1);
        any       = !rst && (hold || req0 || req1);
        gnt0      = any && sel == 1'(P_CPU);
        gnt1      = any && sel == 1'(P_DMA);
        sel_we    = sel ? we1 : we0;
        sel_lock  = sel ? lock1 : lock0;
        sel_addr  = sel ? addr1 : addr0;
        sel_wdata = sel ? wdata1 : wdata0;
        mem_read       = any && !err && !sel_we;
        mem_write      = any && !err && sel_we;
        mem_addr       = 32'(sel_addr);
        mem_write_data = 32'(sel_wdata);
        rdata0 = rsp_valid0 && rd0 && !rsp_err0 ? DATA_W'(mem_read_data) : '0;
        rdata1 = rsp_valid1 && rd1 && !rsp_err1 ? DATA_W'(mem_read_data) : '0;
    end

    dmem_arb_addr_check #(.ADDR_W(ADDR_W)) u_chk (.addr(sel_addr), .err(err));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB;
            owner <= 1'b0;
            prio  <= 1'b0;
            cnt   <= '0;
        end else if (hold) begin
            cnt <= cnt + 4'd1;
            if (!sel_lock || cnt + 4'd1 == 4'(MAX_BURST)) begin
                state <= ARB;
                prio  <= ~owner;
                cnt   <= '0;
            end
        end else begin
            state <= ARB;
            cnt   <= '0;
            if (state == LOCKED)
                prio <= ~owner;
            // a grant in this cycle overrides the exit priority above
            if (any) begin
                prio <= ~sel;
                if (sel_lock && MAX_BURST > 1) begin
                    state <= LOCKED;
                    owner <= sel;
                    cnt   <= 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;
            rsp_err0   <= 1'b0;
            rsp_err1   <= 1'b0;
            rd0        <= 1'b0;
            rd1        <= 1'b0;
        end else begin
            rsp_valid0 <= gnt0;
            rsp_valid1 <= gnt1;
            rsp_err0   <= gnt0 && err;
            rsp_err1   <= gnt1 && err;
            rd0        <= gnt0 && !sel_we;
            rd1        <= gnt1 && !sel_we;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for dmem_arbiter with a 1024x32 memory model
module tb_dmem_arbiter;
    logic        clk, rst;
    logic        req0, we0, lock0, gnt0, rsp_valid0, rsp_err0;
    logic        req1, we1, lock1, gnt1, rsp_valid1, rsp_err1;
    logic [31:0] addr0, wdata0, rdata0, addr1, wdata1, rdata1;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic        mem_read, mem_write;

    typedef struct {int port; logic err; logic [31:0] rdata;} exp_t;
    exp_t q[$];
    int   n_chk = 0, n_fail = 0;

    logic [31:0] store [1024];
    bit          written [1024];

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .gnt0(gnt0), .rsp_valid0(rsp_valid0), .rsp_err0(rsp_err0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .gnt1(gnt1), .rsp_valid1(rsp_valid1), .rsp_err1(rsp_err1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // unwritten word i reads as 0xA0000000 | i
    always @(posedge clk) begin
        if (mem_write) begin
            store[mem_addr[11:2]]   <= mem_write_data;
            written[mem_addr[11:2]] <= 1'b1;
        end
        if (mem_read)
            mem_read_data <= written[mem_addr[11:2]] ? store[mem_addr[11:2]] : (32'hA000_0000 | 32'(mem_addr[11:2]));
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // eg: expected granted port (-1 none); ee/erd: expected response error and read data
    task automatic beat(input logic r0, w0, input logic [31:0] a0, d0, input logic l0,
                        input logic r1, w1, input logic [31:0] a1, d1, input logic l1,
                        input int eg, input logic ee, input logic [31:0] erd, input string nm);
        logic ewe;
        @(posedge clk);
        #1;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0; lock0 = l0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
        @(negedge clk);
        ewe = eg == 1 ? w1 : w0;
        chk({nm, ".gnt0"}, gnt0, eg == 0);
        chk({nm, ".gnt1"}, gnt1, eg == 1);
        chk({nm, ".mem_read"}, mem_read, eg >= 0 && !ee && !ewe);
        chk({nm, ".mem_write"}, mem_write, eg >= 0 && !ee && ewe);
        if (eg >= 0 && !ee) chk({nm, ".mem_addr"}, mem_addr, eg == 1 ? a1 : a0);
        if (eg >= 0 && !ee && ewe) chk({nm, ".mem_wdata"}, mem_write_data, eg == 1 ? d1 : d0);
        if (eg >= 0) q.push_back('{eg, ee, erd});
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid0 || rsp_valid1) begin
                if (q.size() == 0) chk("rsp_unexpected", {30'd0, rsp_valid1, rsp_valid0}, 0);
                else begin
                    e = q.pop_front();
                    chk("rsp_port", {30'd0, rsp_valid1, rsp_valid0}, e.port == 1 ? 2 : 1);
                    chk("rsp_err", e.port == 1 ? rsp_err1 : rsp_err0, e.err);
                    chk("rsp_rdata", e.port == 1 ? rdata1 : rdata0, e.rdata);
                end
            end
        end
    end

    initial begin
        rst = 1;
        {req0, we0, lock0, req1, we1, lock1} = '0;
        {addr0, wdata0, addr1, wdata1} = '0;
        req0 = 1;
        #3;
        chk("rst.gnt0", gnt0, 0);
        chk("rst.mem_read", mem_read, 0);
        chk("rst.rsp_valid0", rsp_valid0, 0);
        chk("rst.rsp_valid1", rsp_valid1, 0);
        chk("rst.rsp_err0", rsp_err0, 0);
        chk("rst.rdata0", rdata0, 0);
        chk("rst.rdata1", rdata1, 0);
        @(posedge clk);
        #1 req0 = 0;
        #1 rst = 0;
        // single read, write then read-back
        beat(1,0,32'h010,0,0, 0,0,0,0,0, 0,0,32'hA000_0004, "rd0");
        beat(0,0,0,0,0, 1,1,32'h0FC,32'hDEADBEEF,0, 1,0,0, "wr1");
        beat(0,0,0,0,0, 1,0,32'h0FC,0,0, 1,0,32'hDEADBEEF, "rdback1");
        // round-robin with both requesting
        beat(1,0,32'h020,0,0, 1,0,32'h024,0,0, 0,0,32'hA000_0008, "rr0");
        beat(1,0,32'h028,0,0, 1,0,32'h024,0,0, 1,0,32'hA000_0009, "rr1");
        beat(1,0,32'h028,0,0, 1,0,32'h02C,0,0, 0,0,32'hA000_000A, "rr2");
        beat(1,0,32'h030,0,0, 1,0,32'h02C,0,0, 1,0,32'hA000_000B, "rr3");
        beat(1,0,32'h030,0,0, 0,0,0,0,0, 0,0,32'hA000_000C, "solo0");
        // locked burst capped at four beats
        beat(1,0,32'h044,0,0, 1,0,32'h080,0,1, 1,0,32'hA000_0020, "bst1");
        beat(1,0,32'h044,0,0, 1,0,32'h084,0,1, 1,0,32'hA000_0021, "bst2");
        beat(1,0,32'h044,0,0, 1,0,32'h088,0,1, 1,0,32'hA000_0022, "bst3");
        beat(1,0,32'h044,0,0, 1,0,32'h08C,0,1, 1,0,32'hA000_0023, "bst4");
        beat(1,0,32'h044,0,0, 1,0,32'h090,0,1, 0,0,32'hA000_0011, "bst_cap");
        beat(1,0,32'h048,0,0, 1,0,32'h090,0,1, 1,0,32'hA000_0024, "bst_again");
        beat(1,0,32'h048,0,0, 1,0,32'h094,0,0, 1,0,32'hA000_0025, "unlock_beat");
        beat(1,0,32'h048,0,0, 1,0,32'h098,0,1, 0,0,32'hA000_0012, "after_unlock");
        // owner drops req: other port granted in the same cycle
        beat(0,0,0,0,0, 1,0,32'h098,0,1, 1,0,32'hA000_0026, "lock_solo");
        beat(1,0,32'h04C,0,0, 0,0,0,0,0, 0,0,32'hA000_0013, "owner_drop");
        // address errors, and the rejected write must not reach memory
        beat(1,0,32'h1000,0,0, 0,0,0,0,0, 0,1,0, "err_range");
        beat(0,0,0,0,0, 1,1,32'h002,32'h12345678,0, 1,1,0, "err_align");
        beat(1,0,32'h000,0,0, 0,0,0,0,0, 0,0,32'hA000_0000, "no_side_effect");
        beat(0,0,0,0,0, 1,0,32'h8000_0010,0,0, 1,1,0, "err_high");
        // async reset in the middle of a burst
        beat(0,0,0,0,0, 1,0,32'h0A0,0,1, 1,0,32'hA000_0028, "pre_rst1");
        beat(1,0,32'h0B0,0,0, 1,0,32'h0A4,0,1, 1,0,32'hA000_0029, "pre_rst2");
        @(posedge clk);
        #1 chk("pre_rst.rsp_valid1", rsp_valid1, 1);
        #1 rst = 1;
        #1;
        chk("async.rsp_valid1", rsp_valid1, 0);
        chk("async.gnt0", gnt0, 0);
        chk("async.gnt1", gnt1, 0);
        chk("async.mem_read", mem_read, 0);
        q.delete();
        {req0, req1, lock1} = '0;
        @(posedge clk);
        #3 rst = 0;
        beat(1,0,32'h0B0,0,0, 1,0,32'h0A4,0,0, 0,0,32'hA000_002C, "post_rst0");
        beat(0,0,0,0,0, 1,0,32'h0A4,0,0, 1,0,32'hA000_0029, "post_rst1");
        beat(0,0,0,0,0, 0,0,0,0,0, -1,0,0, "idle");
        repeat (3) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
